wb_stage: RTL and testbench

Writeback stage of the dCPU integer pipeline, directly upstream of the register file. It merges single-cycle ALU results with load responses from the data-memory interface, buffers one pending load, and drives the register file's single write port (`wren`, `rd_addr`, `reg_data`). It also keeps a scoreboard of destinations with loads in flight, so decode can detect load-use hazards.

---
 rtl/wb_stage_pkg.sv | 33 +++
 rtl/wb_stage_load_ext.sv | 37 +++
 rtl/wb_stage.sv | 131 +++++++++++++
 tb/tb_wb_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the dCPU writeback stage: enable levels, load funct3
// codes, register/data widths and the write-port source selector.
`ifndef WB_STAGE_DEFINES
`define WB_STAGE_DEFINES
`define ENABLE  1'b1
`define DISABLE 1'b0
`define LB      3'b000
`define LH      3'b001
`define LW      3'b010
`define LBU     3'b100
`define LHU     3'b101
`endif

package wb_stage_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    F3_LB  = `LB,
    F3_LH  = `LH,
    F3_LW  = `LW,
    F3_LBU = `LBU,
    F3_LHU = `LHU
  } ld_funct3_e;

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_LOAD = 2'd2
  } wr_sel_e;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Combinational load extender: picks the addressed byte/halfword out of an
// aligned memory word and sign- or zero-extends it to a full register.
module load_ext
  import wb_stage_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] ext
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = '0;
    case (off)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    ext = word;
    case (funct3)
      F3_LB:   ext = DATA_W'(byte_s);
      F3_LBU:  ext = {{(DATA_W-8){1'b0}}, byte_s};
      F3_LH:   ext = DATA_W'(half_s);
      F3_LHU:  ext = {{(DATA_W-16){1'b0}}, half_s};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU results against a one-entry load buffer for
// the register file write port and tracks in-flight load destinations.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [31:0]       alu_data,
  output logic              alu_stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [4:0]        ld_rd,
  input  logic [31:0]       ld_data,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic              ld_issue,
  input  logic [4:0]        ld_issue_rd,
  input  logic [4:0]        rs_addr1,
  input  logic [4:0]        rs_addr2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              wren,
  output logic [4:0]        rd_addr,
  output logic [31:0]       reg_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == LIMIT_C) ? v : v + CW'(1);
  endfunction

  logic                buf_full;
  logic [REG_AW-1:0]   buf_rd_p0;
  logic [DATA_W-1:0]   buf_data_p0;
  logic [CW-1:0]       starve_cnt;
  logic [31:0]         busy;
  logic [31:0]         busy_nxt;
  logic                wb_is_load;
  logic [DATA_W-1:0]   ext_data;

  wr_sel_e             sel;
  logic                force_drain;
  logic                drain;
  logic                accept;
  logic [REG_AW-1:0]   wr_rd;
  logic [DATA_W-1:0]   wr_data;

  load_ext u_load_ext (
    .funct3 (ld_funct3),
    .off    (ld_off),
    .word   (ld_data),
    .ext    (ext_data)
  );

  // Arbitration: a starved buffer wins unconditionally, otherwise the ALU has priority.
  always_comb begin
    force_drain = buf_full && (starve_cnt == LIMIT_C);
    sel         = SEL_IDLE;
    if (force_drain)    sel = SEL_LOAD;
    else if (alu_valid) sel = SEL_ALU;
    else if (buf_full)  sel = SEL_LOAD;
    drain   = (sel == SEL_LOAD);
    accept  = ld_valid && !buf_full;
    wr_rd   = drain ? buf_rd_p0 : alu_rd;
    wr_data = drain ? buf_data_p0 : alu_data;
  end

  assign ld_ready  = !buf_full;
  assign alu_stall = force_drain;

  // ---- stage p0: load buffer and starvation control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full   <= `DISABLE;
      starve_cnt <= '0;
    end else begin
      if (accept)     buf_full <= `ENABLE;
      else if (drain) buf_full <= `DISABLE;

      if (drain)                      starve_cnt <= '0;
      else if (buf_full && alu_valid) starve_cnt <= sat_inc(starve_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_rd_p0   <= ld_rd;
      buf_data_p0 <= ext_data;
    end
  end

  // ---- stage p1: register file write port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren       <= `DISABLE;
      rd_addr    <= '0;
      reg_data   <= '0;
      wb_is_load <= `DISABLE;
    end else begin
      wren       <= (sel != SEL_IDLE) && (wr_rd != '0);
      wb_is_load <= drain && (buf_rd_p0 != '0);
      if (sel != SEL_IDLE) begin
        rd_addr  <= wr_rd;
        reg_data <= wr_data;
      end
    end
  end

  // Scoreboard: a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (wren && wb_is_load) busy_nxt[rd_addr] = 1'b0;
    if (ld_issue)           busy_nxt[ld_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs_addr1];
  assign rs2_busy = busy[rs_addr2];

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by a randomized run against
// a transaction-level reference of the writeback rules.
module tb_wb_stage;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic [4:0]  rs_addr1;
  logic [4:0]  rs_addr2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wren;
  logic [4:0]  rd_addr;
  logic [31:0] reg_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stage #(.STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_stall   (alu_stall),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .ld_funct3   (ld_funct3),
    .ld_off      (ld_off),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .rs_addr1    (rs_addr1),
    .rs_addr2    (rs_addr2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .wren        (wren),
    .rd_addr     (rd_addr),
    .reg_data    (reg_data)
  );

  function automatic logic [31:0] ext_ref(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    int unsigned v;
    case (f3)
      3'b000: begin v = (w >> (8 * off)) & 32'hFF; if (v >= 128) v = v - 256; end
      3'b100: v = (w >> (8 * off)) & 32'hFF;
      3'b001: begin v = (w >> (16 * off[1])) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'b101: v = (w >> (16 * off[1])) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; ld_funct3 = 3'b010; ld_off = 0;
    ld_issue = 0; ld_issue_rd = 0; rs_addr1 = 0; rs_addr2 = 0;
  endtask

  task automatic test_reset;
    tick; tick;
    checks++; if (wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%0b exp=0", wren); end
    checks++; if (rd_addr !== 5'd0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
    checks++; if (reg_data !== 32'd0) begin failures++; $display("FAIL reset_reg_data got=%h exp=0", reg_data); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready got=%0b exp=1", ld_ready); end
    checks++; if (alu_stall !== 1'b0) begin failures++; $display("FAIL reset_alu_stall got=%0b exp=0", alu_stall); end
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL reset_rs1_busy got=%0b exp=0", rs1_busy); end
    rst_n = 1;
    tick;
  endtask

  task automatic test_alu;
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    tick;
    alu_valid = 0;
    checks++; if (wren !== 1'b1) begin failures++; $display("FAIL alu_wren got=%0b exp=1", wren); end
    checks++; if (rd_addr !== 5'd5) begin failures++; $display("FAIL alu_rd_addr got=%0d exp=5", rd_addr); end
    checks++; if (reg_data !== 32'h1234) begin failures++; $display("FAIL alu_reg_data got=%h exp=1234", reg_data); end
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    tick;
    alu_valid = 0;
    checks++; if (wren !== 1'b0) begin failures++; $display("FAIL alu_x0_wren got=%0b exp=0", wren); end
    tick;
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s  [5] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010};
    logic [1:0]  offs [5] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
    logic [31:0] words[5] = '{32'h80FF0000, 32'h80FF0000, 32'h0000F00F, 32'h0000A500, 32'h89ABCDEF};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h000080FF, 32'hFFFFF00F, 32'h000000A5, 32'h89ABCDEF};
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1; ld_rd = 5'd3; ld_funct3 = f3s[i]; ld_off = offs[i]; ld_data = words[i];
      tick;
      ld_valid = 0;
      tick;
      checks++;
      if (wren !== 1'b1 || rd_addr !== 5'd3 || reg_data !== exps[i]) begin
        failures++;
        $display("FAIL load_ext_%0d got wren=%0b rd=%0d data=%h exp wren=1 rd=3 data=%h",
                 i, wren, rd_addr, reg_data, exps[i]);
      end
      tick;
    end
  endtask

  task automatic test_scoreboard;
    rs_addr1 = 7; rs_addr2 = 7;
    ld_issue = 1; ld_issue_rd = 7;
    tick;
    ld_issue = 0;
    checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin failures++; $display("FAIL sb_set got rs1=%0b rs2=%0b exp 1 1", rs1_busy, rs2_busy); end
    ld_valid = 1; ld_rd = 7; ld_funct3 = 3'b010; ld_data = 32'h77;
    tick;
    ld_valid = 0;
    tick;
    checks++; if (wren !== 1'b1 || rd_addr !== 5'd7 || rs1_busy !== 1'b1) begin failures++; $display("FAIL sb_wb_cycle got wren=%0b rd=%0d busy=%0b exp 1 7 1", wren, rd_addr, rs1_busy); end
    tick;
    checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL sb_clear got=%0b exp=0", rs1_busy); end
    ld_issue = 1; ld_issue_rd = 7;
    tick;
    ld_issue = 0; ld_valid = 1;
    tick;
    ld_valid = 0;
    tick;
    ld_issue = 1; ld_issue_rd = 7;
    tick;
    ld_issue = 0;
    checks++; if (rs1_busy !== 1'b1) begin failures++; $display("FAIL sb_set_wins got=%0b exp=1", rs1_busy); end
    ld_valid = 1;
    tick;
    ld_valid = 0;
    tick; tick;
    checks++; if (rs2_busy !== 1'b0) begin failures++; $display("FAIL sb_final_clear got=%0b exp=0", rs2_busy); end
    rs_addr1 = 0; rs_addr2 = 0;
  endtask

  task automatic test_starvation;
    ld_valid = 1; ld_rd = 10; ld_funct3 = 3'b010; ld_data = 32'hCAFE0010;
    tick;
    ld_valid = 0;
    alu_valid = 1; alu_rd = 11; alu_data = 32'h1111;
    for (int k = 1; k <= LIMIT + 1; k++) begin
      #1;
      checks++; if (alu_stall !== (k == LIMIT + 1)) begin failures++; $display("FAIL starve_stall_%0d got=%0b exp=%0b", k, alu_stall, (k == LIMIT + 1)); end
      tick;
      if (k <= LIMIT) begin
        checks++; if (wren !== 1'b1 || rd_addr !== 5'd11) begin failures++; $display("FAIL starve_alu_%0d got wren=%0b rd=%0d exp 1 11", k, wren, rd_addr); end
      end else begin
        checks++; if (wren !== 1'b1 || rd_addr !== 5'd10 || reg_data !== 32'hCAFE0010) begin failures++; $display("FAIL starve_load got wren=%0b rd=%0d data=%h exp 1 10 cafe0010", wren, rd_addr, reg_data); end
      end
    end
    #1;
    checks++; if (alu_stall !== 1'b0) begin failures++; $display("FAIL starve_release got=%0b exp=0", alu_stall); end
    tick;
    alu_valid = 0;
    checks++; if (wren !== 1'b1 || rd_addr !== 5'd11 || reg_data !== 32'h1111) begin failures++; $display("FAIL starve_held_alu got wren=%0b rd=%0d data=%h exp 1 11 1111", wren, rd_addr, reg_data); end
    tick;
  endtask

  task automatic test_backpressure;
    ld_valid = 1; ld_rd = 12; ld_funct3 = 3'b010; ld_data = 32'hD1D1D1D1;
    #1;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_empty got=%0b exp=1", ld_ready); end
    tick;
    ld_rd = 13; ld_data = 32'hD2D2D2D2;
    #1;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%0b exp=0", ld_ready); end
    tick;
    checks++; if (wren !== 1'b1 || rd_addr !== 5'd12 || reg_data !== 32'hD1D1D1D1) begin failures++; $display("FAIL bp_first got wren=%0b rd=%0d data=%h exp 1 12 d1d1d1d1", wren, rd_addr, reg_data); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_drain got=%0b exp=1", ld_ready); end
    tick;
    ld_valid = 0;
    checks++; if (wren !== 1'b0) begin failures++; $display("FAIL bp_gap got=%0b exp=0", wren); end
    tick;
    checks++; if (wren !== 1'b1 || rd_addr !== 5'd13 || reg_data !== 32'hD2D2D2D2) begin failures++; $display("FAIL bp_second got wren=%0b rd=%0d data=%h exp 1 13 d2d2d2d2", wren, rd_addr, reg_data); end
    tick;
  endtask

  task automatic test_reset_mid;
    rs_addr1 = 9; rs_addr2 = 9;
    ld_issue = 1; ld_issue_rd = 9;
    tick;
    ld_issue = 0;
    ld_valid = 1; ld_rd = 9; ld_funct3 = 3'b010; ld_data = 32'h99999999;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    tick;
    ld_valid = 0; alu_valid = 0;
    checks++; if (wren !== 1'b1 || ld_ready !== 1'b0 || rs1_busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre got wren=%0b ready=%0b busy=%0b exp 1 0 1", wren, ld_ready, rs1_busy); end
    rst_n = 0;
    #1;
    checks++; if (wren !== 1'b0 || ld_ready !== 1'b1 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || alu_stall !== 1'b0)
      begin failures++; $display("FAIL rstmid_async got wren=%0b ready=%0b rs1=%0b rs2=%0b stall=%0b exp 0 1 0 0 0", wren, ld_ready, rs1_busy, rs2_busy, alu_stall); end
    #2;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (wren !== 1'b0 || rs1_busy !== 1'b0) begin failures++; $display("FAIL rstmid_post_%0d got wren=%0b busy=%0b exp 0 0", i, wren, rs1_busy); end
    end
    rs_addr1 = 0; rs_addr2 = 0;
  endtask

  task automatic test_random;
    logic        m_full, e_wren, e_load, hold;
    logic [4:0]  m_rd, e_rd;
    logic [31:0] m_data, e_data, m_busy;
    int          m_wait;
    logic        n_full, n_wren, n_load, stall;
    logic [4:0]  n_rd;
    logic [31:0] n_data;
    int          n_wait;
    m_full = 0; e_wren = 0; e_load = 0; hold = 0; m_rd = 0; e_rd = 0;
    m_data = 0; e_data = 0; m_busy = 0; m_wait = 0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd = 5'($urandom_range(0, 31));
        alu_data = $urandom;
      end
      ld_valid = $urandom_range(0, 1);
      ld_rd = 5'($urandom_range(0, 31));
      ld_data = $urandom;
      ld_funct3 = 3'($urandom_range(0, 7));
      ld_off = 2'($urandom_range(0, 3));
      ld_issue = ($urandom_range(0, 2) == 0);
      ld_issue_rd = 5'($urandom_range(0, 31));
      rs_addr1 = 5'($urandom_range(0, 31));
      rs_addr2 = 5'($urandom_range(0, 31));
      #1;
      stall = m_full && (m_wait == LIMIT);
      checks++; if (ld_ready !== !m_full) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, ld_ready, !m_full); end
      checks++; if (alu_stall !== stall) begin failures++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, alu_stall, stall); end
      checks++; if (rs1_busy !== m_busy[rs_addr1] || rs2_busy !== m_busy[rs_addr2])
        begin failures++; $display("FAIL rnd_busy c=%0d got=%0b%0b exp=%0b%0b", c, rs1_busy, rs2_busy, m_busy[rs_addr1], m_busy[rs_addr2]); end

      n_wren = 0; n_rd = e_rd; n_data = e_data; n_load = 0; n_full = m_full; n_wait = m_wait;
      if (stall || (m_full && !alu_valid)) begin
        n_wren = (m_rd != 0); n_rd = m_rd; n_data = m_data; n_load = 1; n_full = 0; n_wait = 0;
      end else if (alu_valid) begin
        n_wren = (alu_rd != 0); n_rd = alu_rd; n_data = alu_data;
        if (m_full && m_wait < LIMIT) n_wait = m_wait + 1;
      end
      if (ld_valid && !m_full) begin
        n_full = 1; m_rd = ld_rd; m_data = ext_ref(ld_funct3, ld_off, ld_data);
      end
      if (e_wren && e_load) m_busy[e_rd] = 1'b0;
      if (ld_issue) m_busy[ld_issue_rd] = 1'b1;
      m_busy[0] = 1'b0;
      hold = stall && alu_valid;
      m_full = n_full; m_wait = n_wait; e_wren = n_wren; e_rd = n_rd; e_data = n_data; e_load = n_load;

      tick;
      checks++; if (wren !== e_wren) begin failures++; $display("FAIL rnd_wren c=%0d got=%0b exp=%0b", c, wren, e_wren); end
      if (e_wren) begin
        checks++; if (rd_addr !== e_rd || reg_data !== e_data)
          begin failures++; $display("FAIL rnd_write c=%0d got rd=%0d data=%h exp rd=%0d data=%h", c, rd_addr, reg_data, e_rd, e_data); end
      end
    end
    idle_inputs;
    tick; tick;
  endtask

  initial begin
    idle_inputs;
    #2 rst_n = 0;
    test_reset;
    test_alu;
    test_load_ext;
    test_scoreboard;
    test_starvation;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
